divisor_algoritmico: RTL and testbench

- Iterative (shift/subtract, restoring) signed integer divider; one quotient bit per clock.
- Computes Coc = Num / Den and Res = Num % Den, with the same semantics as SystemVerilog signed int division.
- Sits behind a start/done handshake driven by a stimulus agent; a scoreboard samples operands on Start and checks the results on Done.

---
 rtl/divisor_algoritmico.sv | 152 +++++++++++++++
 tb/tb_divisor_algoritmico.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_algoritmico.sv
// ---------------------------------------------------------------------------
// divisor_algoritmico
// Iterative restoring signed divider producing one quotient bit per clock.
// Coc = Num / Den and Res = Num % Den, with quotient truncated toward zero
// and the remainder carrying the sign of the dividend.
//
// Ports:
//   CLK    rising-edge clock
//   RSTa   asynchronous active-low reset
//   Start  operation request, honoured only while idle
//   Num    signed dividend, captured on the accepting Start edge
//   Den    signed divisor, captured on the accepting Start edge
//   Coc    signed quotient, registered, held until the next result
//   Res    signed remainder, registered, held until the next result
//   Done   one-cycle pulse marking the cycle Coc/Res become valid
// ---------------------------------------------------------------------------
module divisor_algoritmico #(
    parameter int tamanyo = 32
) (
    input  logic                      CLK,
    input  logic                      RSTa,
    input  logic                      Start,
    input  logic signed [tamanyo-1:0] Num,
    input  logic signed [tamanyo-1:0] Den,
    output logic signed [tamanyo-1:0] Coc,
    output logic signed [tamanyo-1:0] Res,
    output logic                      Done
);

    localparam int CW = (tamanyo > 2) ? $clog2(tamanyo) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OP,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [tamanyo-1:0] quo_q, quo_d;
    logic [tamanyo-1:0] div_q, div_d;
    logic [tamanyo-1:0] rem_q, rem_d;
    logic [CW-1:0]      count_q, count_d;
    logic               sign_coc_q, sign_coc_d;
    logic               sign_res_q, sign_res_d;
    logic [tamanyo-1:0] coc_q, coc_d;
    logic [tamanyo-1:0] res_q, res_d;
    logic               done_q, done_d;

    logic [tamanyo-1:0] num_mag;
    logic [tamanyo-1:0] den_mag;
    logic [tamanyo:0]   rem_shift;

    // Magnitudes are taken as unsigned values so that the most negative
    // operand maps exactly onto 2^(tamanyo-1).
    always_comb begin
        num_mag = Num[tamanyo-1] ? (~$unsigned(Num) + 1'b1) : $unsigned(Num);
        den_mag = Den[tamanyo-1] ? (~$unsigned(Den) + 1'b1) : $unsigned(Den);
    end

    // The shifted partial remainder keeps one extra bit so the compare
    // against the divisor magnitude can never lose a carry.
    always_comb begin
        rem_shift = {rem_q, quo_q[tamanyo-1]};
    end

    // Next-state logic for the controller and the datapath registers.
    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        div_d      = div_q;
        rem_d      = rem_q;
        count_d    = count_q;
        sign_coc_d = sign_coc_q;
        sign_res_d = sign_res_q;
        coc_d      = coc_q;
        res_d      = res_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    quo_d      = num_mag;
                    div_d      = den_mag;
                    rem_d      = '0;
                    sign_coc_d = Num[tamanyo-1] ^ Den[tamanyo-1];
                    sign_res_d = Num[tamanyo-1];
                    count_d    = CW'(tamanyo - 1);
                    state_d    = OP;
                end
            end

            OP: begin
                // A zero divisor always subtracts, which yields an all-ones
                // quotient and leaves |Num| in the remainder.
                if (rem_shift >= {1'b0, div_q}) begin
                    rem_d = rem_shift[tamanyo-1:0] - div_q;
                    quo_d = {quo_q[tamanyo-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[tamanyo-1:0];
                    quo_d = {quo_q[tamanyo-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                coc_d   = sign_coc_q ? (~quo_q + 1'b1) : quo_q;
                res_d   = sign_res_q ? (~rem_q + 1'b1) : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            sign_coc_q <= 1'b0;
            sign_res_q <= 1'b0;
            coc_q      <= '0;
            res_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            count_q    <= count_d;
            sign_coc_q <= sign_coc_d;
            sign_res_q <= sign_res_d;
            coc_q      <= coc_d;
            res_q      <= res_d;
            done_q     <= done_d;
        end
    end

    assign Coc  = $signed(coc_q);
    assign Res  = $signed(res_q);
    assign Done = done_q;

endmodule

// File: tb/tb_divisor_algoritmico.sv
// ---------------------------------------------------------------------------
// tb_divisor_algoritmico
// Directed and random checks of the iterative signed divider. A reference
// model built on integer division predicts Done/Coc/Res every cycle, and
// directed operations are also checked against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_divisor_algoritmico;

   localparam int W = 32;
   localparam int LAT = W + 1;
   localparam int PERIOD = W + 2;
   localparam int NRAND = 1500;

   logic                CLK;
   logic                RSTa;
   logic                Start;
   logic signed [W-1:0] Num;
   logic signed [W-1:0] Den;
   logic signed [W-1:0] Coc;
   logic signed [W-1:0] Res;
   logic                Done;

   int vectors;
   int miscompares;
   bit chkEn;

   // Reference model state
   bit  busy;
   int  cnt;
   int  pendCoc, pendRes;
   int  expCoc, expRes;
   bit  expDone;

   divisor_algoritmico #(.tamanyo(W)) dut (
      .CLK  (CLK),
      .RSTa (RSTa),
      .Start(Start),
      .Num  (Num),
      .Den  (Den),
      .Coc  (Coc),
      .Res  (Res),
      .Done (Done)
   );

   // Free-running clock, 10 time units per period
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Integer-division semantics, with the two cases the language leaves
   // undefined (divide by zero, most-negative / -1) filled in explicitly.
   function automatic int modelCoc(input int n, input int d);
      if (d == 0) return (n < 0) ? 1 : -1;
      if (n == int'(32'h80000000) && d == -1) return n;
      return n / d;
   endfunction

   function automatic int modelRes(input int n, input int d);
      if (d == 0) return n;
      if (n == int'(32'h80000000) && d == -1) return 0;
      return n % d;
   endfunction

   // Transaction-level prediction: an operation accepted at one edge
   // delivers its result LAT edges later; requests while busy are ignored.
   always @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         busy    <= 1'b0;
         cnt     <= 0;
         expDone <= 1'b0;
         expCoc  <= 0;
         expRes  <= 0;
         pendCoc <= 0;
         pendRes <= 0;
      end else begin
         expDone <= 1'b0;
         if (busy) begin
            if (cnt == LAT - 1) begin
               busy    <= 1'b0;
               expDone <= 1'b1;
               expCoc  <= pendCoc;
               expRes  <= pendRes;
            end else begin
               cnt <= cnt + 1;
            end
         end else if (Start) begin
            busy    <= 1'b1;
            cnt     <= 0;
            pendCoc <= modelCoc(Num, Den);
            pendRes <= modelRes(Num, Den);
         end
      end
   end

   task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d (0x%h), required %0d (0x%h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge CLK) begin
      if (chkEn) begin
         checkValue("model_done", {31'b0, Done}, {31'b0, expDone});
         checkValue("model_coc", Coc, expCoc);
         checkValue("model_res", Res, expRes);
      end
   end

   // Present one operation with a single-cycle Start pulse; returns just
   // after the accepting edge.
   task automatic applyStimulus(input int n, input int d);
      @(negedge CLK);
      Num   = n;
      Den   = d;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      Num   = $urandom;
      Den   = $urandom;
   endtask

   // Wait (bounded) for Done, then check latency and results against literals
   task automatic checkOutput(input string name, input int expLat, input int eCoc, input int eRes);
      int lat;
      lat = 0;
      for (int i = 1; i <= LAT + 12; i++) begin
         @(negedge CLK);
         if (Done) begin
            lat = i;
            break;
         end
      end
      checkValue({name, "_latency"}, lat, expLat);
      checkValue({name, "_coc"}, Coc, eCoc);
      checkValue({name, "_res"}, Res, eRes);
   endtask

   initial begin
      int doneCount;
      vectors     = 0;
      miscompares = 0;
      chkEn       = 1'b0;
      RSTa        = 1'b0;
      Start       = 1'b0;
      Num         = '0;
      Den         = '0;

      // Reset, then idle for 50 cycles with no Done expected
      repeat (3) @(negedge CLK);
      RSTa  = 1'b1;
      chkEn = 1'b1;
      checkValue("reset_coc", Coc, 0);
      checkValue("reset_res", Res, 0);
      checkValue("reset_done", {31'b0, Done}, 0);
      doneCount = 0;
      repeat (50) begin
         @(negedge CLK);
         if (Done) doneCount++;
      end
      checkValue("idle_no_done", doneCount, 0);

      // Basic and signed combinations
      applyStimulus(100, 7);
      checkOutput("pos_pos", LAT, 14, 2);
      repeat (5) @(negedge CLK);
      checkValue("hold_coc", Coc, 14);
      checkValue("hold_res", Res, 2);
      applyStimulus(-100, 7);
      checkOutput("neg_pos", LAT, -14, -2);
      applyStimulus(100, -7);
      checkOutput("pos_neg", LAT, -14, 2);

      // Corners
      applyStimulus(int'(32'h80000000), -1);
      checkOutput("min_by_m1", LAT, int'(32'h80000000), 0);
      applyStimulus(int'(32'h80000000), 1);
      checkOutput("min_by_1", LAT, int'(32'h80000000), 0);
      applyStimulus(5, 0);
      checkOutput("div0_pos", LAT, int'(32'hFFFFFFFF), 5);
      applyStimulus(-5, 0);
      checkOutput("div0_neg", LAT, 1, -5);
      applyStimulus(0, 9);
      checkOutput("zero_num", LAT, 0, 0);

      // Start pulse during an operation must be ignored
      applyStimulus(500, -3);
      repeat (5) @(negedge CLK);
      Num   = 12;
      Den   = 4;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      checkOutput("start_in_op", LAT - 6, -166, 2);
      doneCount = 0;
      repeat (45) begin
         @(negedge CLK);
         if (Done) doneCount++;
      end
      checkValue("no_extra_done", doneCount, 0);

      // Leave a nonzero result, then abort an operation with reset
      applyStimulus(-100, -7);
      checkOutput("neg_neg", LAT, 14, -2);
      applyStimulus(1000, 3);
      repeat (9) @(negedge CLK);
      #1 RSTa = 1'b0;
      #1;
      checkValue("abort_coc", Coc, 0);
      checkValue("abort_res", Res, 0);
      checkValue("abort_done", {31'b0, Done}, 0);
      repeat (2) @(negedge CLK);
      RSTa = 1'b1;
      doneCount = 0;
      repeat (50) begin
         @(negedge CLK);
         if (Done) doneCount++;
      end
      checkValue("abort_no_done", doneCount, 0);
      applyStimulus(81, 9);
      checkOutput("after_abort", LAT, 9, 0);

      // Start held high with operands changing every cycle
      doneCount = 0;
      @(negedge CLK);
      Start = 1'b1;
      for (int k = 0; k < NRAND * PERIOD; k++) begin
         int n, d;
         if ($urandom_range(0, 1) == 0) begin
            n = int'($urandom_range(0, 400)) - 200;
            d = int'($urandom_range(0, 40)) - 20;
         end else begin
            n = int'($urandom);
            d = int'($urandom);
         end
         if (d == 0) d = 1;
         Num = n;
         Den = d;
         @(negedge CLK);
         if (Done) doneCount++;
      end
      Start = 1'b0;
      checkValue("stream_done_count", doneCount, NRAND);
      repeat (PERIOD + 4) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global bound so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not complete, required completion before 2000000");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] timeout");
   end

endmodule
